// File: rtl/usr_burst.sv
// Parametrised universal shift register with an FSM-sequenced burst of shifts.
// Optional parity/par_err outputs are enabled by defining USR_BURST_PARITY_EN.
module usr_burst #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [2:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
    input  logic              start,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              busy,
    output logic              done
`ifdef USR_BURST_PARITY_EN
    ,
    output logic              parity,
    output logic              par_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        mode_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  rem_q;
    logic [WIDTH-1:0]  q_r, shifted, ones, fill_l, fill_r;
    logic              take, shift_en;
    int                rot;

    assign ones = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!load && start) begin
                    take    = 1'b1;
                    state_d = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                shift_en = 1'b1;
                if (rem_q <= CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifts past the register width saturate to the fill value naturally.
    always_comb begin
        rot     = int'(step_q) % WIDTH;
        fill_l  = ser_in ? ~(ones << step_q) : '0;
        fill_r  = ser_in ? ~(ones >> step_q) : '0;
        shifted = q_r;
        unique case (mode_q)
            3'b000: shifted = q_r;
            3'b001: shifted = q_r << step_q;
            3'b010: shifted = q_r >> step_q;
            3'b011: shifted = $unsigned($signed(q_r) >>> step_q);
            3'b100: shifted = (q_r << rot) | (q_r >> (WIDTH - rot));
            3'b101: shifted = (q_r >> rot) | (q_r << (WIDTH - rot));
            3'b110: shifted = (q_r << step_q) | fill_l;
            3'b111: shifted = (q_r >> step_q) | fill_r;
            default: shifted = q_r;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            mode_q <= '0;
            step_q <= '0;
            rem_q  <= '0;
        end else begin
            if (state_q == IDLE && load) begin
                q_r <= d_in;
            end else if (shift_en) begin
                q_r   <= shifted;
                rem_q <= rem_q - CNT_W'(1);
            end
            if (take) begin
                mode_q <= mode;
                step_q <= step;
                rem_q  <= count;
            end
        end
    end

    assign q    = q_r;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        ser_out = q_r[0];
        if (mode_q == 3'b001 || mode_q == 3'b100 || mode_q == 3'b110)
            ser_out = q_r[WIDTH-1];
    end

`ifdef USR_BURST_PARITY_EN
    logic par_cap;

    assign parity = ^q_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_cap <= 1'b0;
            par_err <= 1'b0;
        end else if (take) begin
            par_cap <= parity;
            par_err <= 1'b0;
        end else if (state_q == DONE && parity != par_cap) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/usr_burst.md
Name: usr_burst

Overview:
- Parametrised universal shift register; successor to the team's 4-bit load/shift-left/shift-right register.
- Adds:
  - logical, arithmetic, rotate and serial-in shift modes
  - multi-bit step per operation
  - FSM-sequenced burst of N repeated shift operations with a start/busy/done handshake
- Used by datapath blocks needing serialisation, barrel-style alignment or timed bit-streaming.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- STEP_W, 3, width of the step-amount input; step range 0..2^STEP_W-1.
- CNT_W, 4, width of the burst-count input; count range 0..2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- load  input  1  parallel load request
- d_in  input  WIDTH  parallel load data
- mode  input  3  shift operation, sampled on start
- step  input  STEP_W  bits shifted per operation, sampled on start
- count  input  CNT_W  number of operations in burst, sampled on start
- start  input  1  burst request
- ser_in  input  1  serial fill bit for modes 110/111, sampled live every RUN cycle
- q  output  WIDTH  register contents
- ser_out  output  1  serial output bit
- busy  output  1  high while burst executing
- done  output  1  one-cycle pulse after burst completes

Behaviour:
- Reset (async, immediate):
  - q=0, state=IDLE, busy=0, done=0.
  - Latched mode/step/remaining-count cleared to 0, so ser_out=q[0]=0.
- FSM states:
  - IDLE:
    - load=1: q<=d_in next edge; load has priority over start.
    - else start=1: latch mode, step and count.
      - count==0: go to DONE, no shift.
      - otherwise: go to RUN with remaining=count; no shift on this edge.
    - else: hold q.
  - RUN:
    - Each edge: apply the latched op once, remaining-=1.
    - When remaining==1 at the edge, go to DONE.
    - load and start are ignored in RUN.
    - Changes on mode/step/count are ignored; ser_in is used live.
  - DONE: one cycle, then IDLE; load and start are ignored.
- Outputs: busy = (state==RUN); done = (state==DONE). Both are registered state decodes.
- Latency: start sampled at edge E0; shifts at E1..Ecount; busy high between E0 and Ecount; done high for the cycle after Ecount.
- Mode encoding (s = latched step):
  - 000 hold (RUN cycles consumed, q unchanged)
  - 001 SLL zero-fill
  - 010 SRL zero-fill
  - 011 SRA sign-fill from q[WIDTH-1]
  - 100 ROL
  - 101 ROR
  - 110 SLS: shift left, vacated LSBs filled with ser_in
  - 111 SRS: shift right, vacated MSBs filled with ser_in
- Step rules:
  - s=0: no change to q, but the operation still counts.
  - s>=WIDTH, shift modes: logical → all zeros; SRA → all sign bits; serial modes → all ser_in.
  - Rotate modes use s mod WIDTH.
- ser_out: q[WIDTH-1] when latched mode is 001/100/110; otherwise q[0]. Combinational from q and the latched mode.
- Width: all shifts are computed at WIDTH bits; no carry out.

Optional Feature:
- Macro USR_BURST_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = XOR-reduction of q, combinational; 0 after reset.
  - Adds output port par_err (1 bit), registered, set in DONE when parity differs from its value captured at start; cleared on the next start or reset.
- Undefined: neither port exists; no parity logic.

Test Plan (WIDTH=8, STEP_W=3, CNT_W=4):
- Load: load=1, d_in=0xB4 → q=0xB4 next edge; busy=0, done=0.
- SRA: from q=0xB4, start with mode=011, step=2, count=1 → q=0xED after E1; busy high one cycle; done pulse one cycle after E1.
- ROL burst: from q=0x81, start with mode=100, step=3, count=2 → q=0x0C after E1, q=0x60 after E2; busy 2 cycles; done 1 cycle; load=1 and start=1 driven mid-burst have no effect.
- Serial-in: from q=0x00, start with mode=110, step=1, count=4, ser_in=1 → q=0x0F; ser_out=q[7]=0 throughout.
- Zero count: start with count=0 → done pulses the cycle after E0; busy never high; q unchanged.
- Reset mid-burst: assert rst during RUN (SRL, step=1, count=8, q=0xFF) → q=0, busy=0, done=0 immediately, FSM in IDLE; a fresh start afterwards works normally.
